scc_mem_arbiter: RTL and testbench
==================================

Name: scc_mem_arbiter

Overview:
Shares one unified memory port between the SCC core's instruction-fetch and data-access interfaces. It sits between the SCC core and the single-port memory model inside the SCC top-level wrapper. Each access is a request/acknowledge transaction with one-cycle completion pulses back to the core. Fixed data-over-fetch priority applies, with a burst limit that prevents fetch starvation.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
MAX_DATA_BURST, 4, max consecutive data grants while a fetch is pending (>=1)
TIMEOUT_CYCLES, 255, mem_req cycles before abort (used only with SCC_ARB_TIMEOUT_EN)

Ports:
clk  in  1  main clock
reset  in  1  asynchronous, active-high; sets all regs to known state
if_req  in  1  fetch request from core (in_mem_en); held until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, valid when if_valid=1
if_valid  out  1  one-cycle fetch completion pulse
d_read  in  1  data read request; held until d_valid
d_write  in  1  data write request; held until d_valid
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data, valid when d_valid=1 after a read
d_valid  out  1  one-cycle data completion pulse
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, sampled when mem_ack=1
mem_ack  in  1  memory completion; meaningful only while mem_req=1
busy  out  1  1 while state != IDLE
arb_err  out  1  sticky timeout flag (tied 0 without macro)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high, every output is 0 and the FSM is in IDLE.
- FSM states: IDLE, GNT_I, GNT_D. All outputs are registered.
- IDLE arbitration, data pending = d_read|d_write:
  - Grant data if data is pending, unless a fetch is pending and burst_cnt == MAX_DATA_BURST.
  - Otherwise grant fetch if if_req is set.
  - Requesters whose valid output is high in the current cycle are masked from arbitration.
- burst_cnt:
  - Increments on each data grant while if_req=1, saturating at MAX_DATA_BURST.
  - Clears on any fetch grant, or on a data grant when if_req=0.
- On grant, the next cycle:
  - mem_req=1.
  - mem_addr, mem_wdata and mem_we are latched from the granted requester.
  - If d_read and d_write are both 1, the access is a write (mem_we=1).
  - State moves to GNT_I or GNT_D.
- Request hold: mem_addr, mem_wdata and mem_we stay stable while mem_req=1. Requester input changes during a grant are ignored.
- Completion: on a cycle with mem_ack=1 in GNT_x, the next cycle:
  - mem_req=0 and state returns to IDLE.
  - The matching valid output pulses for exactly 1 cycle.
  - For reads, if_rdata or d_rdata captures mem_rdata.
  - For writes, d_rdata is unchanged.
- Latency: request at cycle 0 → mem_req at cycle 1 → ack at earliest cycle 1 → valid at cycle 2. Minimum spacing between transactions is 3 cycles.
- Requesters may present a new request in the cycle after their valid pulse.
- mem_ack while mem_req=0 is ignored.
- rdata outputs hold their last value until the next read completion.
- Reset mid-transaction: the in-flight access is abandoned, mem_req drops asynchronously, burst_cnt is cleared, and no valid pulse is issued.

Optional Feature:
SCC_ARB_TIMEOUT_EN
- Defined:
  - A counter runs while mem_req=1.
  - If it reaches TIMEOUT_CYCLES without mem_ack, the next cycle: mem_req=0, the granted valid pulses, and for reads the rdata output is 32'hDEADBEEF. arb_err sets sticky until reset, and the FSM returns to IDLE.
  - The counter clears on every grant.
- Undefined: no counter. The arbiter waits indefinitely for mem_ack, and arb_err is constant 0.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x100; mem_ack at cycle 3 with mem_rdata=0xE3A00001 → mem_req cycles 1-3, mem_addr=0x100, mem_we=0; if_valid at cycle 4, if_rdata=0xE3A00001.
2. Simultaneous if_req and d_read (d_addr=0x2000), 1-cycle ack → data served first (d_valid, then d_rdata). The fetch is granted in the next IDLE; if_valid follows 3 cycles after d_valid.
3. Starvation: if_req held, d_read re-asserted after every d_valid, MAX_DATA_BURST=4 → exactly 4 data completions, then a fetch grant, then burst_cnt=0.
4. d_read=d_write=1, d_wdata=0x12345678 → mem_we=1 and mem_wdata=0x12345678; d_valid pulses and d_rdata is unchanged.
5. reset asserted while mem_req=1 and mem_ack never seen → all outputs 0 immediately and no valid pulse. After release, a new fetch completes normally.
6. With SCC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, d_read with mem_ack never asserted → mem_req drops after 8 cycles; d_valid pulses with d_rdata=0xDEADBEEF; arb_err stays 1 until reset.

Source files
------------

// File: rtl/scc_mem_arbiter.sv
// Shares one memory port between SCC instruction fetch and data access (data first, burst-limited).
// Define SCC_ARB_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES and raise sticky arb_err.
module scc_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              arb_err
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam int                BW           = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0]     BURST_MAX    = BW'(MAX_DATA_BURST);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

    state_t            state, state_nx;
    logic [BW-1:0]     burst_cnt, burst_nx;
    logic              mem_req_nx, mem_we_nx, if_valid_nx, d_valid_nx, busy_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx, if_rdata_nx, d_rdata_nx, done_data;
    logic              data_pend, done, timed_out;

    assign data_pend = d_read | d_write;
    assign done      = mem_ack | timed_out;
    assign done_data = mem_ack ? mem_rdata : TIMEOUT_DATA;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            if_rdata  <= if_rdata_nx;
            d_rdata   <= d_rdata_nx;
            if_valid  <= if_valid_nx;
            d_valid   <= d_valid_nx;
            busy      <= busy_nx;
        end
    end

    // No grant while a valid pulse is out: the finishing requester is still holding its
    // request, and the idle turnaround gives the 3-cycle transaction spacing.
    always_comb begin
        state_nx     = state;
        burst_nx     = burst_cnt;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        if_rdata_nx  = if_rdata;
        d_rdata_nx   = d_rdata;
        if_valid_nx  = 1'b0;
        d_valid_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (!if_valid && !d_valid) begin
                    if (data_pend && !(if_req && burst_cnt == BURST_MAX)) begin
                        state_nx     = GNT_D;
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = d_write;
                        mem_addr_nx  = d_addr;
                        mem_wdata_nx = d_wdata;
                        // Cannot exceed BURST_MAX here: at the limit the fetch wins instead.
                        burst_nx     = if_req ? burst_cnt + BW'(1) : '0;
                    end else if (if_req) begin
                        state_nx     = GNT_I;
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = 1'b0;
                        mem_addr_nx  = if_addr;
                        mem_wdata_nx = '0;
                        burst_nx     = '0;
                    end
                end
            end
            GNT_I: begin
                if (done) begin
                    state_nx    = IDLE;
                    mem_req_nx  = 1'b0;
                    if_valid_nx = 1'b1;
                    if_rdata_nx = done_data;
                end
            end
            GNT_D: begin
                if (done) begin
                    state_nx   = IDLE;
                    mem_req_nx = 1'b0;
                    d_valid_nx = 1'b1;
                    if (!mem_we) begin
                        d_rdata_nx = done_data;
                    end
                end
            end
            default: begin
                state_nx   = IDLE;
                mem_req_nx = 1'b0;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

`ifdef SCC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          err_flag;

    assign timed_out = (state != IDLE) && !mem_ack && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign arb_err   = err_flag;

    // to_cnt holds the number of mem_req cycles already spent on the current grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt   <= '0;
            err_flag <= 1'b0;
        end else begin
            to_cnt <= (state == IDLE) ? '0 : to_cnt + TW'(1);
            if (timed_out) begin
                err_flag <= 1'b1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
    assign arb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Scoreboard bench for scc_mem_arbiter: directed fetch/data traffic against a simple memory responder.
module tb_scc_mem_arbiter;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int MAX_DATA_BURST = 4;
    localparam int TIMEOUT_CYCLES = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req, d_read, d_write, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_valid, mem_req, mem_we, busy, arb_err;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    exp_t        sb[$];
    dreq_t       d_q[$];
    logic [31:0] f_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic ack_enable = 1'b1;
    logic spurious_ack = 1'b0;
    int   ack_delay = 0;
    int   last_dvalid_cyc = 0;
    int   last_ivalid_cyc = 0;
    int   req_rise_cyc = 0;
    int   req_len = 0;

    scc_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_DATA_BURST(MAX_DATA_BURST), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .arb_err(arb_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hE3A00001;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic is_data, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        dreq_t r;
        if (is_data) begin
            r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata;
            d_q.push_back(r);
        end else begin
            f_q.push_back(addr);
        end
    endtask

    task automatic expectTxn(input logic is_data, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.is_data = is_data; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic waitDone(input string tag, input int max_cyc);
        int n = 0;
        while ((sb.size() != 0 || f_q.size() != 0 || d_q.size() != 0 || busy) && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, 64'(n < max_cyc), 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Core-side requesters: hold the head request until its valid pulse, then move on.
    initial begin : fetch_core
        if_req = 1'b0; if_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if_req = 1'b0;
            end else begin
                if (if_valid && f_q.size() > 0) void'(f_q.pop_front());
                if (f_q.size() > 0) begin
                    if_req = 1'b1; if_addr = f_q[0];
                end else begin
                    if_req = 1'b0;
                end
            end
        end
    end

    initial begin : data_core
        dreq_t r;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                d_read = 1'b0; d_write = 1'b0;
            end else begin
                if (d_valid && d_q.size() > 0) void'(d_q.pop_front());
                if (d_q.size() > 0) begin
                    r = d_q[0];
                    d_read = r.rd; d_write = r.wr; d_addr = r.addr; d_wdata = r.wdata;
                end else begin
                    d_read = 1'b0; d_write = 1'b0;
                end
            end
        end
    end

    initial begin : responder
        int wait_cnt;
        wait_cnt = 0; mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && ack_enable) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1; mem_rdata = mem_fn(mem_addr); wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (!mem_req && spurious_ack) begin
                    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
                end
            end
        end
    end

    initial begin : monitor
        logic        prev_req, hold_we;
        logic [31:0] hold_addr, hold_wdata, i_model, d_model;
        exp_t        e;
        prev_req = 1'b0; hold_we = 1'b0; hold_addr = '0; hold_wdata = '0;
        i_model = '0; d_model = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0; i_model = '0; d_model = '0;
                continue;
            end
            if (mem_req && !prev_req) begin
                req_rise_cyc = cyc;
                checkOutput("grant_expected", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb[0];
                    checkOutput("grant_we", mem_we, e.we);
                    checkOutput("grant_addr", mem_addr, e.addr);
                    if (e.we) checkOutput("grant_wdata", mem_wdata, e.wdata);
                end
                hold_we = mem_we; hold_addr = mem_addr; hold_wdata = mem_wdata;
            end else if (mem_req) begin
                checkOutput("hold_addr", mem_addr, hold_addr);
                checkOutput("hold_we_wdata", {mem_we, mem_wdata}, {hold_we, hold_wdata});
            end
            if (prev_req && !mem_req) req_len = cyc - req_rise_cyc;
            if (if_valid || d_valid) begin
                checkOutput("valid_expected", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("valid_kind", {if_valid, d_valid}, e.is_data ? 2'b01 : 2'b10);
                    if (e.is_data) begin
                        if (!e.we) d_model = e.rdata;
                        last_dvalid_cyc = cyc;
                    end else begin
                        i_model = e.rdata;
                        last_ivalid_cyc = cyc;
                    end
                    checkOutput("if_rdata", if_rdata, i_model);
                    checkOutput("d_rdata", d_rdata, d_model);
                end
            end
            prev_req = mem_req;
        end
    end

    initial begin : main
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_valids", {if_valid, d_valid}, 0);
        checkOutput("rst_rdata", {if_rdata, d_rdata}, 0);
        checkOutput("rst_busy_err", {busy, arb_err}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        $display("[TB] fetch only, ack after 3 request cycles");
        ack_delay = 2;
        expectTxn(0, 0, 32'h100, 0, mem_fn(32'h100));
        applyStimulus(0, 0, 0, 32'h100, 0);
        waitDone("t1", 50);
        checkOutput("t1_req_len", 64'(req_len), 3);
        checkOutput("t1_if_rdata", if_rdata, 32'hE3A00001);

        $display("[TB] simultaneous fetch and data read");
        ack_delay = 0;
        expectTxn(1, 0, 32'h2000, 0, mem_fn(32'h2000));
        expectTxn(0, 0, 32'h104, 0, mem_fn(32'h104));
        applyStimulus(1, 1, 0, 32'h2000, 0);
        applyStimulus(0, 0, 0, 32'h104, 0);
        waitDone("t2", 50);
        checkOutput("t2_ivalid_gap", 64'(last_ivalid_cyc - last_dvalid_cyc), 3);

        $display("[TB] data burst limit with fetch held");
        for (int i = 0; i < 4; i++) expectTxn(1, 0, 32'h3000 + 32'(4 * i), 0, mem_fn(32'h3000 + 32'(4 * i)));
        expectTxn(0, 0, 32'h200, 0, mem_fn(32'h200));
        expectTxn(1, 0, 32'h3010, 0, mem_fn(32'h3010));
        expectTxn(1, 0, 32'h3014, 0, mem_fn(32'h3014));
        expectTxn(0, 0, 32'h204, 0, mem_fn(32'h204));
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 32'h3000 + 32'(4 * i), 0);
        applyStimulus(0, 0, 0, 32'h200, 0);
        applyStimulus(0, 0, 0, 32'h204, 0);
        waitDone("t3", 300);

        $display("[TB] read+write collision is a write; plain write");
        expectTxn(1, 1, 32'h4000, 32'h12345678, 0);
        expectTxn(1, 1, 32'h4004, 32'hCAFEF00D, 0);
        applyStimulus(1, 1, 1, 32'h4000, 32'h12345678);
        applyStimulus(1, 0, 1, 32'h4004, 32'hCAFEF00D);
        waitDone("t4", 50);
        checkOutput("t4_d_rdata_kept", d_rdata, mem_fn(32'h3014));

        $display("[TB] mem_ack while idle is ignored");
        spurious_ack = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("spur_state", {mem_req, busy, if_valid, d_valid}, 0);
        checkOutput("spur_rdata", {if_rdata, d_rdata}, {mem_fn(32'h204), mem_fn(32'h3014)});
        spurious_ack = 1'b0;

        $display("[TB] reset during an unacknowledged fetch");
        ack_enable = 1'b0;
        expectTxn(0, 0, 32'h300, 0, mem_fn(32'h300));
        applyStimulus(0, 0, 0, 32'h300, 0);
        n = 0;
        while (!mem_req && n < 20) begin
            @(posedge clk);
            n++;
        end
        checkOutput("t5_req_seen", 64'(n < 20), 1);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_async_req", {mem_req, busy, mem_we}, 0);
        checkOutput("t5_async_addr", mem_addr, 0);
        checkOutput("t5_async_rdata", {if_rdata, d_rdata}, 0);
        sb.delete(); f_q.delete(); d_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        ack_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            checkOutput("t5_no_valid", {if_valid, d_valid, mem_req}, 0);
        end
        expectTxn(0, 0, 32'h108, 0, mem_fn(32'h108));
        applyStimulus(0, 0, 0, 32'h108, 0);
        waitDone("t5_after", 50);
        checkOutput("t5_if_rdata", if_rdata, mem_fn(32'h108));

`ifdef SCC_ARB_TIMEOUT_EN
        $display("[TB] timeout on unacknowledged data read");
        ack_enable = 1'b0;
        expectTxn(1, 0, 32'h5000, 0, 32'hDEADBEEF);
        applyStimulus(1, 1, 0, 32'h5000, 0);
        waitDone("t6", 60);
        ack_enable = 1'b1;
        checkOutput("t6_req_len", 64'(req_len), TIMEOUT_CYCLES);
        checkOutput("t6_d_rdata", d_rdata, 32'hDEADBEEF);
        checkOutput("t6_arb_err", arb_err, 1);
        expectTxn(0, 0, 32'h10C, 0, mem_fn(32'h10C));
        applyStimulus(0, 0, 0, 32'h10C, 0);
        waitDone("t6_after", 50);
        checkOutput("t6_arb_err_sticky", arb_err, 1);
        reset = 1'b1;
        #1;
        checkOutput("t6_arb_err_reset", arb_err, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
`else
        checkOutput("arb_err_tied", arb_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
